uart_tx_result_seq: RTL and testbench
=====================================

Name: uart_tx_result_seq

Overview:
Sequences transmission of the 16-bit ALU result over the UART transmitter after the RX controller pulses its trigger. It latches the result and sends it least-significant byte first. Each byte is handed to the UART TX core with a one-cycle start pulse, then the block waits for the core to finish. It sits between the ALU output and the UART TX core, mirroring the RX-side controller.

Parameters:
WAIT_FOR_REGISTER_DELAY, 100, cycles tx_data is held stable before each tx_start pulse
BUSY_TIMEOUT, 1000, max cycles to wait for tx_busy to rise after tx_start before aborting

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
trigger  in  1  one-cycle request to send the current result
result  in  16  ALU result, sampled on accepted trigger
tx_busy  in  1  UART TX core busy, high while a byte is shifting out
tx_start  out  1  one-cycle pulse to the UART TX core to send tx_data
tx_data  out  8  byte presented to the UART TX core
seq_busy  out  1  high from accepted trigger until return to IDLE
tx_error  out  1  one-cycle pulse on timeout abort
state_dbg  out  4  current state encoding, for the LEDs

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; tx_start=0, tx_data=0, seq_busy=0, tx_error=0; latched result=0; byte index=0; timer=0.
- States and transitions:
  - IDLE: on trigger=1, latch result, byte index=0, go to LOAD.
  - LOAD: tx_data <= selected byte (index 0 = result[7:0], index 1 = result[15:8]); clear timer; go to HOLD.
  - HOLD: timer increments each cycle; when timer >= WAIT_FOR_REGISTER_DELAY, go to START.
  - START: tx_start=1 for exactly this one cycle; clear timer; go to WAIT_BUSY_HI.
  - WAIT_BUSY_HI: on tx_busy=1, go to WAIT_BUSY_LO. Otherwise, when timer >= BUSY_TIMEOUT, pulse tx_error and go to IDLE.
  - WAIT_BUSY_LO: on tx_busy=0, go to NEXT. No timeout in this state.
  - NEXT: if index = last byte, go to IDLE; else increment index and go to LOAD.
- tx_data stays stable from LOAD until the next LOAD; it is not cleared on return to IDLE.
- Latency: trigger to first tx_start = WAIT_FOR_REGISTER_DELAY + 3 cycles.
- seq_busy = (state != IDLE), registered.
- Trigger outside IDLE is ignored. It is not queued, and the latched result is not changed.
- tx_busy already high when entering WAIT_BUSY_HI is accepted immediately.
- Timer is 32-bit unsigned and saturates; it never wraps.
- If reset is asserted mid-transfer, the block returns to IDLE at once and tx_start drops asynchronously. A partially sent result is not resumed.
- State encoding is a 4-bit enum; state_dbg = state.

Optional Feature:
TX_FLAGS_BYTE_EN:
- Defined: adds input flags[4:0] (ALU flags N,Z,C,V,P), latched together with result. A third byte {3'b000, flags} is sent after the MSB; the last byte index is 2.
- Not defined: no flags port; the last byte index is 1.

Decomposition:
- Package uart_ctrl_pkg:
  - state enum typedef;
  - constants for LSB/MSB/FLAGS byte indices and number of bytes (depends on macro);
  - byte-select function.
- Sub-module hold_timer: 32-bit saturating counter with clear and enable, plus a compare output against a limit input. Instantiated once and shared between the HOLD and WAIT_BUSY_HI states.

Test Plan:
- Normal send, WAIT_FOR_REGISTER_DELAY=4, BUSY_TIMEOUT=50: result=16'hA55A, trigger; TX model asserts busy for 10 cycles after each start -> bytes 8'h5A then 8'hA5, exactly 2 tx_start pulses, first at trigger+7 cycles; seq_busy falls after the second busy falls.
- Timeout: same parameters, tx_busy held 0 -> one tx_start, then tx_error pulse 51 cycles later; state IDLE; no second byte.
- Trigger ignored while busy: result=16'h1234, trigger; mid-transfer result=16'hFFFF with a second trigger -> bytes 8'h34, 8'h12 only; no extra transfer.
- Reset mid-transfer: assert reset during WAIT_BUSY_LO of byte 0 -> all outputs 0 immediately. After release, trigger with 16'h00C3 -> clean transfer of 8'hC3, 8'h00.
- tx_busy already high at START: busy stuck at 1 for 5 cycles -> block advances to WAIT_BUSY_LO the next cycle; no tx_error.
- With TX_FLAGS_BYTE_EN: result=16'h0001, flags=5'b10101 -> bytes 8'h01, 8'h00, 8'h15; 3 tx_start pulses.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART result sequencer: state encoding, byte indices, byte select.
// Byte count depends on the optional TX_FLAGS_BYTE_EN macro.
package uart_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_LOAD         = 4'd1,
        ST_HOLD         = 4'd2,
        ST_START        = 4'd3,
        ST_WAIT_BUSY_HI = 4'd4,
        ST_WAIT_BUSY_LO = 4'd5,
        ST_NEXT         = 4'd6
    } state_e;

    localparam logic [1:0] BYTE_LSB   = 2'd0;
    localparam logic [1:0] BYTE_MSB   = 2'd1;
    localparam logic [1:0] BYTE_FLAGS = 2'd2;

`ifdef TX_FLAGS_BYTE_EN
    localparam int unsigned NUM_BYTES = 3;
`else
    localparam int unsigned NUM_BYTES = 2;
`endif

    localparam logic [1:0] BYTE_LAST = 2'(NUM_BYTES - 1);

    function automatic logic [7:0] select_byte(
        input logic [1:0]  idx,
        input logic [15:0] res,
        input logic [4:0]  flags
    );
        logic [7:0] b;
        case (idx)
            BYTE_LSB:   b = res[7:0];
            BYTE_MSB:   b = res[15:8];
            BYTE_FLAGS: b = {3'b000, flags};
            default:    b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// 32-bit saturating cycle counter with synchronous clear and count enable,
// plus a ">= limit" compare on the current count.
module hold_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] limit_i,
    output logic        ge_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign ge_o = (count_q >= limit_i);

endmodule

// File: rtl/uart_tx_result_seq.sv
// Sends the latched 16-bit ALU result over the UART TX core, LSB first, one start pulse per byte.
// Optional TX_FLAGS_BYTE_EN adds a flags input and a third {3'b000, flags} byte.
module uart_tx_result_seq
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_FOR_REGISTER_DELAY = 100,
    parameter int unsigned BUSY_TIMEOUT            = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] result,
`ifdef TX_FLAGS_BYTE_EN
    input  logic [4:0]  flags,
`endif
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        seq_busy,
    output logic        tx_error,
    output logic [3:0]  state_dbg
);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        seq_busy_q;
    logic        tx_start_q;
    logic [4:0]  flags_in;

    logic        tmr_clr;
    logic        tmr_en;
    logic        tmr_ge;
    logic [31:0] tmr_limit;
    logic        abort_c;

`ifdef TX_FLAGS_BYTE_EN
    assign flags_in = flags;
`else
    assign flags_in = '0;
`endif

    // One timer serves both the data-settle hold and the busy-rise timeout.
    assign tmr_limit = (state_q == ST_HOLD) ? 32'(WAIT_FOR_REGISTER_DELAY)
                                            : 32'(BUSY_TIMEOUT);

    hold_timer u_hold_timer (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .ge_o    (tmr_ge)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        result_d  = result_q;
        flags_d   = flags_q;
        tx_data_d = tx_data_q;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        abort_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    result_d = result;
                    flags_d  = flags_in;
                    idx_d    = BYTE_LSB;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_data_d = select_byte(idx_q, result_q, flags_q);
                tmr_clr   = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                tmr_en = 1'b1;
                if (tmr_ge) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tmr_clr = 1'b1;
                state_d = ST_WAIT_BUSY_HI;
            end
            ST_WAIT_BUSY_HI: begin
                tmr_en = 1'b1;
                if (tx_busy) begin
                    state_d = ST_WAIT_BUSY_LO;
                end else if (tmr_ge) begin
                    abort_c = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BUSY_LO: begin
                if (!tx_busy) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == BYTE_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // tx_start and seq_busy are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            tx_data_q  <= '0;
            seq_busy_q <= 1'b0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            tx_data_q  <= tx_data_d;
            seq_busy_q <= (state_d != ST_IDLE);
            tx_start_q <= (state_d == ST_START);
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign seq_busy  = seq_busy_q;
    assign tx_error  = abort_c;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_result_seq.sv
// Self-checking bench for uart_tx_result_seq: vector table plus hand-written corner sequences,
// with a byte scoreboard checked on every tx_start and a simple TX core model.
module tb_uart_tx_result_seq;

    localparam int unsigned WAIT_DLY = 4;
    localparam int unsigned TIMEOUT  = 50;
    localparam int unsigned BUSY_LEN = 10;
`ifdef TX_FLAGS_BYTE_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] result = '0;
    logic [4:0]  flags = '0;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        seq_busy;
    logic        tx_error;
    logic [3:0]  state_dbg;

    logic        model_busy = 1'b0;
    logic        force_busy = 1'b0;
    int          model_mode = 1;  // 1: respond to tx_start with BUSY_LEN busy cycles, 0: never respond
    int          busy_left = 0;

    assign tx_busy = model_busy | force_busy;

    uart_tx_result_seq #(
        .WAIT_FOR_REGISTER_DELAY (WAIT_DLY),
        .BUSY_TIMEOUT            (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .result    (result),
`ifdef TX_FLAGS_BYTE_EN
        .flags     (flags),
`endif
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .seq_busy  (seq_busy),
        .tx_error  (tx_error),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int fall_cyc = 0;
    int busy_fall_cyc = 0;
    int trig_cyc = 0;
    logic seq_busy_prev = 1'b0;
    logic [7:0] exp_q[$];
    int start_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard and TX core model, all on the falling edge.
    always @(negedge clk) begin
        if (tx_start) begin
            start_cnt++;
            start_cyc_q.push_back(cyc);
            check("start_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("tx_data_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
        if (tx_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (seq_busy_prev && !seq_busy) fall_cyc = cyc;
        seq_busy_prev = seq_busy;

        if (!reset) begin
            busy_left  = 0;
            model_busy = 1'b0;
        end else if (model_mode == 1 && tx_start) begin
            busy_left  = BUSY_LEN;
            model_busy = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                model_busy    = 1'b0;
                busy_fall_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [15:0] r, input logic [4:0] f);
        @(negedge clk);
        result   = r;
        flags    = f;
        trigger  = 1'b1;
        trig_cyc = cyc;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!seq_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [3:0] st, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (state_dbg == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int s0;
        int e0;
        logic [7:0] last_b;

        vecs[0] = '{16'hA55A, 5'b00000, 8'h5A, 8'hA5, 8'h00};
        vecs[1] = '{16'h1234, 5'b11111, 8'h34, 8'h12, 8'h1F};
        vecs[2] = '{16'hFFFF, 5'b00001, 8'hFF, 8'hFF, 8'h01};
        vecs[3] = '{16'h0000, 5'b10000, 8'h00, 8'h00, 8'h10};
        vecs[4] = '{16'h8001, 5'b01010, 8'h01, 8'h80, 8'h0A};
        vecs[5] = '{16'h0001, 5'b10101, 8'h01, 8'h00, 8'h15};

        // Reset state
        #12;
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_seq_busy", {31'd0, seq_busy}, 32'd0);
        check("rst_tx_error", {31'd0, tx_error}, 32'd0);
        check("rst_state", {28'd0, state_dbg}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven normal transfers
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v].b0);
            exp_q.push_back(vecs[v].b1);
            last_b = vecs[v].b1;
            if (NB == 3) begin
                exp_q.push_back(vecs[v].b2);
                last_b = vecs[v].b2;
            end
            start_cyc_q.delete();
            s0 = start_cnt;
            e0 = err_cnt;
            send(vecs[v].res, vecs[v].flg);
            check("vec_seq_busy_set", {31'd0, seq_busy}, 32'd1);
            wait_idle(500, ok);
            check("vec_idle_reached", {31'd0, ok}, 32'd1);
            @(negedge clk);
            check("vec_start_count", 32'(start_cnt - s0), 32'(NB));
            if (start_cyc_q.size() != 0)
                check("vec_first_start_latency", 32'(start_cyc_q[0] - trig_cyc), 32'(WAIT_DLY + 3));
            check("vec_seq_busy_fall", 32'(fall_cyc - busy_fall_cyc), 32'd2);
            check("vec_sb_drained", 32'(exp_q.size()), 32'd0);
            check("vec_tx_data_held", {24'd0, tx_data}, {24'd0, last_b});
            check("vec_state_idle", {28'd0, state_dbg}, 32'd0);
            check("vec_no_error", 32'(err_cnt - e0), 32'd0);
        end

        // Timeout: TX core never raises busy
        model_mode = 0;
        exp_q.push_back(8'hEF);
        start_cyc_q.delete();
        s0 = start_cnt;
        e0 = err_cnt;
        send(16'hBEEF, 5'b00000);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (err_cnt != e0) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_error_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        if (start_cyc_q.size() != 0)
            check("to_error_delay", 32'(err_cyc - start_cyc_q[0]), 32'(TIMEOUT + 1));
        check("to_state_idle", {28'd0, state_dbg}, 32'd0);
        check("to_seq_busy_low", {31'd0, seq_busy}, 32'd0);
        repeat (60) @(negedge clk);
        check("to_single_start", 32'(start_cnt - s0), 32'd1);
        check("to_single_error", 32'(err_cnt - e0), 32'd1);
        check("to_sb_drained", 32'(exp_q.size()), 32'd0);
        model_mode = 1;

        // Trigger while busy is ignored
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        if (NB == 3) exp_q.push_back(8'h00);
        s0 = start_cnt;
        send(16'h1234, 5'b00000);
        repeat (20) @(negedge clk);
        check("ign_mid_transfer", {31'd0, seq_busy}, 32'd1);
        send(16'hFFFF, 5'b11111);
        wait_idle(500, ok);
        check("ign_idle_reached", {31'd0, ok}, 32'd1);
        @(negedge clk);
        check("ign_start_count", 32'(start_cnt - s0), 32'(NB));
        check("ign_sb_drained", 32'(exp_q.size()), 32'd0);
        repeat (40) @(negedge clk);
        check("ign_no_extra_start", 32'(start_cnt - s0), 32'(NB));
        check("ign_stays_idle", {31'd0, seq_busy}, 32'd0);

        // tx_busy already high when START is issued
        model_mode = 0;
        force_busy = 1'b1;
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h3C);
        if (NB == 3) exp_q.push_back(8'h00);
        s0 = start_cnt;
        e0 = err_cnt;
        send(16'h3C96, 5'b00000);
        wait_state(4'd3, 100, ok);
        check("stk_start_reached", {31'd0, ok}, 32'd1);
        @(negedge clk);
        check("stk_wait_hi", {28'd0, state_dbg}, 32'd4);
        @(negedge clk);
        check("stk_wait_lo", {28'd0, state_dbg}, 32'd5);
        repeat (3) @(negedge clk);
        force_busy = 1'b0;
        model_mode = 1;
        wait_idle(500, ok);
        check("stk_idle_reached", {31'd0, ok}, 32'd1);
        @(negedge clk);
        check("stk_start_count", 32'(start_cnt - s0), 32'(NB));
        check("stk_no_error", 32'(err_cnt - e0), 32'd0);
        check("stk_sb_drained", 32'(exp_q.size()), 32'd0);

        // Reset during WAIT_BUSY_LO of byte 0
        exp_q.push_back(8'h78);
        send(16'h5678, 5'b00000);
        wait_state(4'd5, 100, ok);
        check("rmt_wait_lo_reached", {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rmt_tx_start", {31'd0, tx_start}, 32'd0);
        check("rmt_tx_data", {24'd0, tx_data}, 32'd0);
        check("rmt_seq_busy", {31'd0, seq_busy}, 32'd0);
        check("rmt_tx_error", {31'd0, tx_error}, 32'd0);
        check("rmt_state", {28'd0, state_dbg}, 32'd0);
        check("rmt_sb_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rmt_stays_idle", {28'd0, state_dbg}, 32'd0);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h00);
        if (NB == 3) exp_q.push_back(8'h00);
        s0 = start_cnt;
        send(16'h00C3, 5'b00000);
        wait_idle(500, ok);
        check("rmt_idle_reached", {31'd0, ok}, 32'd1);
        @(negedge clk);
        check("rmt_start_count", 32'(start_cnt - s0), 32'(NB));
        check("rmt_sb_after", 32'(exp_q.size()), 32'd0);
        check("rmt_tx_data_held", {24'd0, tx_data}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
